// File: rtl/frame_capture_pkg.sv
// Shared definitions for the frame capture block.
//   - cap_state_e      : capture FSM states (IDLE / FILL / DONE)
//   - DEF_DATA_W       : default pixel width
//   - DEF_ADDR_W       : default frame-buffer address width
//   - DEF_FRAME_PIXELS : default pixels per frame
//   - CKSUM_W          : frame checksum width
package frame_capture_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_FRAME_PIXELS = 12288;
    localparam int CKSUM_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/capture_addr_cnt.sv
// Frame-buffer write address counter.
// Clearable, enabled up-counter that saturates at LAST and flags it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one (ignored once count == LAST)
//   count      : current write address
//   tc         : terminal count, high while count == LAST
module capture_addr_cnt
    import frame_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAST   = DEF_FRAME_PIXELS - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST_V = ADDR_W'(LAST);

    assign tc = (count == LAST_V);

    // Holding at LAST keeps a full 2^ADDR_W frame from wrapping to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/frame_capture.sv
// Frame capture responder: while addr_add is held high, accepts sensor
// pixels and writes them to consecutive frame-buffer addresses, then
// raises fin (4-phase handshake with addr_add).
// Optional feature macro: FRAME_CAPTURE_CKSUM_EN adds the cksum port and
// a running 16-bit sum of the accepted pixels.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   addr_add            : capture request level from the sequencer
//   pix_valid, pix_data : sensor pixel stream
//   pix_ready           : pixel accepted this cycle when valid (FILL only)
//   mem_we/addr/wdata   : frame-buffer write port, one cycle after accept
//   fin                 : frame stored, held until addr_add drops
//   busy                : high in FILL
//   overrun             : sticky, pixel offered while not ready during a request
//   cksum               : frame checksum (FRAME_CAPTURE_CKSUM_EN only)
// FRAME_PIXELS must lie in 1 .. 2**ADDR_W.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               addr_add,
    input  logic               pix_valid,
    input  logic [DATA_W-1:0]  pix_data,
    output logic               pix_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               fin,
    output logic               busy,
    output logic               overrun
`ifdef FRAME_CAPTURE_CKSUM_EN
    ,
    output logic [CKSUM_W-1:0] cksum
`endif
);

    cap_state_e        state, state_next;
    logic              accept;
    logic              cnt_clr;
    logic              cnt_tc;
    logic [ADDR_W-1:0] count;

    // pix_ready is a register that is high exactly while in FILL, so an
    // accept can only happen in FILL.
    assign accept = pix_valid && pix_ready;

    capture_addr_cnt #(
        .ADDR_W (ADDR_W),
        .LAST   (FRAME_PIXELS - 1)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (accept),
        .count (count),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dropped request wins over the final accept: that write still
    // issues, but the frame is treated as aborted and fin stays low.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (addr_add) begin
                    state_next = ST_FILL;
                    cnt_clr    = 1'b1;
                end
            end
            ST_FILL: begin
                if (!addr_add) begin
                    state_next = ST_IDLE;
                end else if (accept && cnt_tc) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!addr_add) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            fin       <= 1'b0;
        end else begin
            pix_ready <= (state_next == ST_FILL);
            busy      <= (state_next == ST_FILL);
            fin       <= (state_next == ST_DONE);
        end
    end

    // Write port: address/data only move on an accept, we is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= count;
                mem_wdata <= pix_data;
            end
        end
    end

    // FILL entry clears overrun even if a pixel is offered in that same
    // cycle: the new frame starts with a clean flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (cnt_clr) begin
            overrun <= 1'b0;
        end else if (pix_valid && !pix_ready && addr_add) begin
            overrun <= 1'b1;
        end
    end

`ifdef FRAME_CAPTURE_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum <= '0;
        end else if (cnt_clr) begin
            cksum <= '0;
        end else if (accept) begin
            cksum <= cksum + CKSUM_W'(pix_data);
        end
    end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture with a 16-pixel frame.
// Directed scenarios followed by a randomized run, all checked against a
// cycle-level behavioural model of the capture protocol.
module tb_frame_capture;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int FP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          addr_add = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          fin;
    logic          busy;
    logic          overrun;
`ifdef FRAME_CAPTURE_CKSUM_EN
    logic [15:0]   cksum;
`endif

    frame_capture #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_add  (addr_add),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .fin       (fin),
        .busy      (busy),
        .overrun   (overrun)
`ifdef FRAME_CAPTURE_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: "capturing" = frame in progress, "stored" = full frame waiting
    // for the request to drop; n = pixels taken so far in this frame.
    bit capturing, stored, e_ovr, e_we;
    int n, sum, e_addr, e_data;
    int wr_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        capturing = 0; stored = 0; e_ovr = 0; e_we = 0;
        n = 0; sum = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic mdl_step(input bit v, input int d, input bit a);
        bit acc;
        acc  = v && capturing;
        e_we = acc;
        if (acc) begin
            e_addr = n;
            e_data = d;
            sum    = (sum + d) % 65536;
            n++;
        end
        if (v && !capturing && a) e_ovr = 1;
        if (!capturing && !stored) begin
            if (a) begin
                capturing = 1; n = 0; sum = 0; e_ovr = 0;
            end
        end else if (capturing) begin
            if (!a) capturing = 0;
            else if (n == FP) begin
                capturing = 0; stored = 1;
            end
        end else if (!a) begin
            stored = 0;
        end
    endtask

    task automatic chk_all();
        chk("pix_ready", 32'(pix_ready), 32'(capturing));
        chk("busy", 32'(busy), 32'(capturing));
        chk("fin", 32'(fin), 32'(stored));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
        end
        if (mem_we) wr_cnt++;
`ifdef FRAME_CAPTURE_CKSUM_EN
        chk("cksum", 32'(cksum), 32'(sum));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(pix_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fin"}, 32'(fin), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
`ifdef FRAME_CAPTURE_CKSUM_EN
        chk({tag, "_cksum"}, 32'(cksum), 0);
`endif
    endtask

    // Drive inputs, let one edge pass, update the model, check 1ns later.
    task automatic step(input bit v, input int d, input bit a);
        pix_valid = v;
        pix_data  = DW'(d);
        addr_add  = a;
        @(posedge clk);
        mdl_step(v, d, a);
        #1;
        chk_all();
    endtask

    task automatic release_req();
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        mdl_reset();
        wr_cnt = 0;
        #2;
        chk_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Continuous frame 0x00..0x0F, then hold request a few cycles.
        step(0, 0, 1);
        wr_cnt = 0;
        for (int i = 0; i < FP; i++) step(1, i, 1);
        chk("fin_after_last", 32'(fin), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("frame1_writes", 32'(wr_cnt), 16);
`ifdef FRAME_CAPTURE_CKSUM_EN
        chk("cksum_ramp", 32'(cksum), 32'h0078);
`endif
        chk("frame1_ovr", 32'(overrun), 0);
        release_req();

        // Valid toggled every other cycle.
        step(0, 0, 1);
        for (int i = 0; i < FP; i++) begin
            step(1, i, 1);
            step(0, 0, 1);
        end
        release_req();

        // Abort after 5 accepts, then restart from address 0.
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'hA0 + i, 1);
        release_req();
        chk("abort_fin", 32'(fin), 0);
        step(0, 0, 1);
        step(1, 8'h5A, 1);
        chk("restart_addr", 32'(mem_addr), 0);
        for (int i = 1; i < FP; i++) step(1, i, 1);

        // Valid held after fin: no writes, overrun set; cleared on re-entry.
        for (int i = 0; i < 4; i++) step(1, 8'h33, 1);
        chk("ovr_after_fin", 32'(overrun), 1);
        release_req();
        step(0, 0, 1);
        chk("ovr_cleared", 32'(overrun), 0);

        // Asynchronous reset at accept 8.
        for (int i = 0; i < 8; i++) step(1, 8'h40 + i, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        mdl_reset();
        addr_add  = 1'b0;
        pix_valid = 1'b0;
        #1 rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 8'h77, 1);
        chk("post_reset_addr", 32'(mem_addr), 0);
        for (int i = 1; i < FP; i++) step(1, 8'h77, 1);
        release_req();

        // All-ones frame.
        step(0, 0, 1);
        for (int i = 0; i < FP; i++) step(1, 8'hFF, 1);
        step(0, 0, 1);
        chk("fin_ff", 32'(fin), 1);
`ifdef FRAME_CAPTURE_CKSUM_EN
        chk("cksum_ff", 32'(cksum), 32'h0FF0);
`endif
        release_req();

        // Randomized run: request mostly high; no pixel offered on the
        // cycle the request drops or first rises.
        begin
            bit a, a_prev, v;
            a_prev = 0;
            for (int c = 0; c < 1500; c++) begin
                a = ($urandom_range(0, 39) != 0);
                v = ($urandom_range(0, 3) != 0);
                if (!a || !a_prev) v = 0;
                step(v, int'($urandom_range(0, 255)), a);
                a_prev = a;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
